// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer for the PC block: run/halt control, hazard stalls,
// a one-entry redirect buffer and a post-redirect flush window.
module pc_fetch_ctrl #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             halt_req,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  input  logic             br_req,
  input  logic [XLEN-1:0]  br_offset,
  output logic             br_ack,
  input  logic             jmp_req,
  input  logic             jmp_abs,
  input  logic [XLEN-1:0]  jmp_target,
  output logic             jmp_ack,
  output logic             start,
  output logic             stop,
  output logic             stall,
  output logic             branch_taken,
  output logic             jump_taken,
  output logic             jump_location,
  output logic [XLEN-1:0]  branch_offset,
  output logic [XLEN-1:0]  new_pc_offset,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [3:0]       flush_cnt, flush_cnt_nxt;
  logic             pend_valid, pend_jmp, pend_abs;
  logic [XLEN-1:0]  br_off_q, jmp_tgt_q;
  logic             issue;

  // Redirect handshake: a requester holds br_req/jmp_req (and its payload)
  // until it sees the matching ack high at a rising edge; the payload is
  // captured on that same edge and the requester may drop the request after.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    start         = 1'b0;
    stop          = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    halted        = 1'b0;
    br_ack        = 1'b0;
    jmp_ack       = 1'b0;
    branch_taken  = 1'b0;
    jump_taken    = 1'b0;
    jump_location = 1'b0;
    issue         = 1'b0;

    if (state == S_RUN || state == S_FLUSH) begin
      stall = hazard_stall | ~imem_ready;
    end

    case (state)
      S_IDLE, S_HALT: begin
        halted = (state == S_HALT);
        start  = start_req & rst_n;
        if (start_req) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          stop      = 1'b1;
          state_nxt = S_HALT;
        end else if (pend_valid) begin
          if (!stall) begin
            issue         = 1'b1;
            branch_taken  = ~pend_jmp;
            jump_taken    = pend_jmp;
            jump_location = pend_jmp & pend_abs;
            state_nxt     = S_FLUSH;
            flush_cnt_nxt = FLUSH_INIT;
          end
        end else begin
          // Branch wins a tie; the jump request simply stays asserted.
          br_ack  = br_req;
          jmp_ack = jmp_req & ~br_req;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (halt_req) begin
          stop          = 1'b1;
          state_nxt     = S_HALT;
          flush_cnt_nxt = 4'd0;
        end else if (!stall) begin
          if (flush_cnt <= 4'd1) begin
            state_nxt     = S_RUN;
            flush_cnt_nxt = 4'd0;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flush_cnt    <= 4'd0;
      pend_valid   <= 1'b0;
      pend_jmp     <= 1'b0;
      pend_abs     <= 1'b0;
      br_off_q     <= '0;
      jmp_tgt_q    <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (stop || issue) begin
        pend_valid <= 1'b0;
      end else if (br_ack) begin
        pend_valid <= 1'b1;
        pend_jmp   <= 1'b0;
        br_off_q   <= br_offset;
      end else if (jmp_ack) begin
        pend_valid <= 1'b1;
        pend_jmp   <= 1'b1;
        pend_abs   <= jmp_abs;
        jmp_tgt_q  <= jmp_target;
      end
      if (issue) begin
        redirect_cnt <= redirect_cnt + CNT_ONE;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  // Offsets come straight from the buffer so they hold between redirects.
  assign branch_offset = br_off_q;
  assign new_pc_offset = jmp_tgt_q;
  assign state_dbg     = state;

endmodule
